// File: rtl/cobs_decode.sv
// Streaming COBS decoder: turns a 0x00-delimited encoded byte stream back into payload bytes.
// A one-byte hold register delays each decoded byte so o_last can be attached when the delimiter arrives.
module cobs_decode #(
    localparam int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_last,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last,
    output logic          o_err
);

    typedef enum logic {CODE, DATA} state_t;

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic          ff, ff_n;
    logic          pend, pend_n;
    logic [DW-1:0] hold_data;
    logic          hold_full;

    logic          accept;
    logic          push;
    logic [DW-1:0] push_byte;
    logic          flush;
    logic          err;
    logic          clear;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    always_comb begin
        push      = 1'b0;
        push_byte = i_data;
        flush     = 1'b0;
        err       = 1'b0;
        clear     = 1'b0;
        state_n   = state;
        cnt_n     = cnt;
        ff_n      = ff;
        pend_n    = pend;
        if (accept) begin
            if (i_last && i_data != '0) begin
                // Truncated frame: the marked byte itself is dropped.
                flush = 1'b1;
                err   = 1'b1;
                clear = 1'b1;
            end else if (state == CODE) begin
                if (i_data == '0) begin
                    flush  = 1'b1;
                    pend_n = 1'b0;
                    ff_n   = 1'b0;
                end else begin
                    if (pend) begin
                        push      = 1'b1;
                        push_byte = '0;
                    end
                    ff_n = (i_data == '1);
                    if (i_data == DW'(1)) begin
                        pend_n = 1'b1;
                    end else begin
                        cnt_n   = i_data - 8'd1;
                        pend_n  = 1'b0;
                        state_n = DATA;
                    end
                end
            end else begin
                if (i_data == '0) begin
                    flush = 1'b1;
                    err   = 1'b1;
                    clear = 1'b1;
                end else begin
                    push  = 1'b1;
                    cnt_n = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_n = CODE;
                        pend_n  = !ff;
                    end
                end
            end
        end
        if (clear) begin
            state_n = CODE;
            cnt_n   = '0;
            ff_n    = 1'b0;
            pend_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CODE;
            cnt       <= '0;
            ff        <= 1'b0;
            pend      <= 1'b0;
            hold_data <= '0;
            hold_full <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ff    <= ff_n;
            pend  <= pend_n;
            o_err <= err;

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end

            // Accepting a byte guarantees the output slot is free this cycle.
            if ((push || flush) && hold_full) begin
                o_data  <= hold_data;
                o_valid <= 1'b1;
                o_last  <= flush;
            end

            if (flush) begin
                hold_full <= 1'b0;
            end else if (push) begin
                hold_data <= push_byte;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cobs_decode.sv
// Directed bench for cobs_decode: per-scenario tasks with hand-computed expected beats.
module tb_cobs_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_last;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;
    logic       o_err;

    cobs_decode dut (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_last (i_last),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_last (o_last),
        .o_err  (o_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_d[$];
    logic       rx_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    int         err_cnt;
    int         err_long;
    int         stall_viol;
    int         timeouts;
    logic       gap_mode   = 1'b0;
    logic       stall_mode = 1'b0;

    // Output monitor, sampled on the falling edge.
    initial begin
        logic       pv, pr, pl, perr;
        logic [7:0] pd;
        pv = 0; pr = 0; pl = 0; perr = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (pv && !pr && (o_valid !== 1'b1 || o_data !== pd || o_last !== pl))
                    stall_viol++;
                if (o_valid && i_ready) begin
                    rx_d.push_back(o_data);
                    rx_l.push_back(o_last);
                end
                if (o_err === 1'b1) begin
                    err_cnt++;
                    if (perr) err_long++;
                end
            end
            pv = o_valid; pr = i_ready; pd = o_data; pl = o_last; perr = o_err;
        end
    end

    // Downstream ready: always high, or random low stretches of 1-5 cycles.
    initial begin
        int hold_n;
        hold_n  = 0;
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                i_ready = 1'b1;
            end else if (hold_n > 0) begin
                i_ready = 1'b0;
                hold_n--;
            end else begin
                i_ready = 1'b1;
                if ($urandom_range(0, 2) == 0) hold_n = $urandom_range(1, 5);
            end
        end
    end

    task automatic clear_logs();
        rx_d.delete(); rx_l.delete(); exp_d.delete(); exp_l.delete();
        err_cnt = 0; err_long = 0; stall_viol = 0; timeouts = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int   n;
        logic acc;
        if (gap_mode) begin
            while ($urandom_range(0, 2) == 0) begin
                i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        i_data = b; i_last = l; i_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) timeouts++;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (rx_d.size() < exp_d.size() && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (rx_d.size() < exp_d.size()) timeouts++;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Frame builders: stimulus plus the payload each one must decode to.
    task automatic frame_basic();
        send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        expect_beat(8'h01, 0); expect_beat(8'h02, 0);
        expect_beat(8'h03, 0); expect_beat(8'h04, 1);
    endtask

    task automatic frame_zeros();
        send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        send_byte(8'h02, 0); send_byte(8'h33, 0); send_byte(8'h00, 0);
        expect_beat(8'h11, 0); expect_beat(8'h22, 0);
        expect_beat(8'h00, 0); expect_beat(8'h33, 1);
        send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        expect_beat(8'h00, 1);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
    endtask

    task automatic frame_max(input logic trailing_one);
        send_byte(8'hFF, 0);
        for (int unsigned v = 1; v <= 254; v++) begin
            send_byte(8'(v), 0);
            expect_beat(8'(v), v == 254);
        end
        if (trailing_one) send_byte(8'h01, 0);
        send_byte(8'h00, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_err !== 1'b0 || o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b err=%b data=%h, want 0/0/0/00",
                     o_valid, o_last, o_err, o_data);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_basic();
        clear_logs();
        frame_basic();
        wait_out();
        checks++;
        if (rx_d.size() != exp_d.size() || timeouts != 0) begin
            errors++;
            $display("FAIL basic_count: got %0d beats (timeouts %0d) want %0d", rx_d.size(), timeouts, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL basic_err: got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_zeros();
        clear_logs();
        frame_zeros();
        wait_out();
        checks++;
        if (rx_d.size() != exp_d.size() || timeouts != 0) begin
            errors++;
            $display("FAIL zeros_count: got %0d beats (timeouts %0d) want %0d", rx_d.size(), timeouts, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL zeros_beat%0d: got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL zeros_err: got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_max_group();
        clear_logs();
        frame_max(1'b0);
        frame_max(1'b1);
        wait_out();
        checks++;
        if (rx_d.size() != exp_d.size() || timeouts != 0) begin
            errors++;
            $display("FAIL max_count: got %0d beats (timeouts %0d) want %0d", rx_d.size(), timeouts, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL max_beat%0d: got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL max_err: got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_back_to_back_stall();
        clear_logs();
        gap_mode = 1'b1; stall_mode = 1'b1;
        frame_basic();
        frame_zeros();
        frame_max(1'b0);
        frame_max(1'b1);
        wait_out();
        gap_mode = 1'b0; stall_mode = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rx_d.size() != exp_d.size() || timeouts != 0) begin
            errors++;
            $display("FAIL stall_count: got %0d beats (timeouts %0d) want %0d", rx_d.size(), timeouts, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d changes while stalled want 0", stall_viol);
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL stall_err: got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_errors();
        // Premature delimiter inside a group.
        clear_logs();
        send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h00, 0);
        wait_out();
        checks++;
        if (rx_d.size() != 1 || rx_d[0] !== 8'h11 || rx_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL premature_out: got %0d beats first %h/%b want 1 beat 11/1",
                     rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 8'hxx, rx_l.size() > 0 ? rx_l[0] : 1'bx);
        end
        checks++;
        if (err_cnt != 1 || err_long != 0) begin
            errors++;
            $display("FAIL premature_err: got %0d pulses (%0d long) want 1 single-cycle", err_cnt, err_long);
        end
        // Recovery frame.
        clear_logs();
        send_byte(8'h02, 0); send_byte(8'hAA, 0); send_byte(8'h00, 0);
        wait_out();
        checks++;
        if (rx_d.size() != 1 || rx_d[0] !== 8'hAA || rx_l[0] !== 1'b1 || err_cnt != 0) begin
            errors++;
            $display("FAIL recover_out: got %0d beats first %h err %0d want 1 beat AA/1 err 0",
                     rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 8'hxx, err_cnt);
        end
        // Truncated by i_last on a nonzero byte.
        clear_logs();
        send_byte(8'h03, 0); send_byte(8'h55, 0); send_byte(8'h66, 1);
        wait_out();
        checks++;
        if (rx_d.size() != 1 || rx_d[0] !== 8'h55 || rx_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL trunc_out: got %0d beats first %h/%b want 1 beat 55/1",
                     rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 8'hxx, rx_l.size() > 0 ? rx_l[0] : 1'bx);
        end
        checks++;
        if (err_cnt != 1 || err_long != 0) begin
            errors++;
            $display("FAIL trunc_err: got %0d pulses (%0d long) want 1 single-cycle", err_cnt, err_long);
        end
    endtask

    task automatic test_midreset();
        clear_logs();
        send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got %b want 0", o_valid);
        end
        clear_logs();
        send_byte(8'h02, 0); send_byte(8'h7E, 0); send_byte(8'h00, 0);
        wait_out();
        checks++;
        if (rx_d.size() != 1 || rx_d[0] !== 8'h7E || rx_l[0] !== 1'b1 || err_cnt != 0) begin
            errors++;
            $display("FAIL midreset_frame: got %0d beats first %h/%b err %0d want 1 beat 7E/1 err 0",
                     rx_d.size(), rx_d.size() > 0 ? rx_d[0] : 8'hxx, rx_l.size() > 0 ? rx_l[0] : 1'bx, err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00;
        test_reset();
        test_basic();
        test_zeros();
        test_max_group();
        test_back_to_back_stall();
        test_errors();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
